// File: rtl/fifo_async_rst.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides and an
// asynchronous active-low reset. Depth is 2**M words of Nb bits.
module fifo_async_rst #(
  parameter int unsigned Nb = 48,
  parameter int unsigned M  = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [Nb-1:0] in_data,
  output logic [M:0]    in_count,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [Nb-1:0] out_data,
  output logic [M:0]    out_count
);

  localparam int unsigned D         = 2 ** M;
  localparam logic [M:0]  CountFull = (M + 1)'(D);

  logic [Nb-1:0] mem_q [D];
  logic [M-1:0]  wr_ptr_q, wr_ptr_d;
  logic [M-1:0]  rd_ptr_q, rd_ptr_d;
  logic [M:0]    count_q, count_d;
  logic          wr_en, rd_en;

  // Handshake flags come only from the registered count, never from in_valid/out_ready.
  assign in_ready  = (count_q != CountFull);
  assign out_valid = (count_q != '0);
  assign wr_en     = in_valid && in_ready;
  assign rd_en     = out_valid && out_ready;

  // Storage is not reset; gating with out_valid keeps out_data at zero when empty.
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign in_count  = count_q;
  assign out_count = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && reset_n) mem_q[wr_ptr_q] <= in_data;
  end

`ifndef SYNTHESIS
  // An underflow wraps count above D, so one bound catches both directions.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (count_q <= CountFull)
        else $error("fifo_async_rst: count %0d out of range", count_q);
      assert (count_q[M-1:0] == M'(wr_ptr_q - rd_ptr_q))
        else $error("fifo_async_rst: count disagrees with pointers");
    end
  end
`endif

endmodule

// File: tb/tb_fifo_async_rst.sv
// Directed and random stimulus for fifo_async_rst, checked against a queue model of a
// depth-4 first-in first-out buffer.
module tb_fifo_async_rst;

  localparam int unsigned Nb = 48;
  localparam int unsigned M  = 2;
  localparam int unsigned D  = 4;

  logic          sample_clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [Nb-1:0] in_data;
  logic [M:0]    in_count;
  logic          out_valid;
  logic          out_ready;
  logic [Nb-1:0] out_data;
  logic [M:0]    out_count;

  logic [Nb-1:0] model_q [$];
  int unsigned   checks = 0;
  int unsigned   errors = 0;

  always #5 sample_clk = ~sample_clk;

  fifo_async_rst #(.Nb(Nb), .M(M)) dut (
    .clk      (sample_clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_count (in_count),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic check_model(input string tag);
    int unsigned n;
    logic [Nb-1:0] head;
    n    = model_q.size();
    head = (n != 0) ? model_q[0] : '0;
    check({tag, ".in_ready"},  64'(in_ready),  64'(n != D));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(n != 0));
    check({tag, ".in_count"},  64'(in_count),  64'(n));
    check({tag, ".out_count"}, 64'(out_count), 64'(n));
    check({tag, ".out_data"},  64'(out_data),  64'(head));
  endtask

  // Starts 1 time unit after a rising edge, ends 1 time unit after the next one.
  task automatic cycle(input string tag, input logic iv, input logic [Nb-1:0] d,
                       input logic ordy);
    bit wr, rd;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    check_model(tag);
    wr = iv && (model_q.size() < D) && reset_n;
    rd = ordy && (model_q.size() > 0) && reset_n;
    @(posedge sample_clk);
    #1;
    if (rd) void'(model_q.pop_front());
    if (wr) model_q.push_back(d);
  endtask

  initial begin
    logic [Nb-1:0] rnd;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    #2;
    check("reset.in_ready",  64'(in_ready),  64'd1);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.in_count",  64'(in_count),  64'd0);
    check("reset.out_count", 64'(out_count), 64'd0);
    check("reset.out_data",  64'(out_data),  64'd0);
    #10;
    reset_n = 1'b1;
    @(posedge sample_clk);
    #1;

    cycle("idle", 1'b0, '0, 1'b1);
    cycle("single_wr", 1'b1, 48'h123456_abcdef, 1'b0);
    check("single.out_data", 64'(out_data), 64'h123456_abcdef);
    cycle("single_rd", 1'b0, '0, 1'b1);
    check("single.count_after", 64'(out_count), 64'd0);

    for (int i = 1; i <= 4; i++) cycle("fill", 1'b1, Nb'(i), 1'b0);
    check("full.in_ready", 64'(in_ready), 64'd0);
    cycle("fill5", 1'b1, 48'd5, 1'b0);
    check("full.count_stays", 64'(in_count), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      check("drain.order", 64'(out_data), 64'(i));
      cycle("drain", 1'b0, '0, 1'b1);
    end

    for (int i = 0; i < 12; i++) begin
      check("stream.count_le1", 64'(out_count <= 1), 64'd1);
      if (i >= 1 && i <= 10) check("stream.seq", 64'(out_data), 64'(i - 1));
      cycle("stream", i < 10, Nb'(i), 1'b1);
    end

    cycle("sim_a", 1'b1, 48'hA0, 1'b0);
    cycle("sim_b", 1'b1, 48'hB0, 1'b0);
    cycle("sim_wr_rd", 1'b1, 48'hC0, 1'b1);
    check("sim.count", 64'(out_count), 64'd2);
    check("sim.head", 64'(out_data), 64'hB0);
    cycle("sim_drain1", 1'b0, '0, 1'b1);
    check("sim.tail", 64'(out_data), 64'hC0);
    cycle("sim_drain2", 1'b0, '0, 1'b1);

    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, Nb'(48'h70 + i), 1'b0);
    check("pre_rst.count", 64'(out_count), 64'd3);
    reset_n = 1'b0;
    #1;
    model_q.delete();
    check("midrst.out_valid", 64'(out_valid), 64'd0);
    check("midrst.in_count",  64'(in_count),  64'd0);
    check("midrst.out_count", 64'(out_count), 64'd0);
    check("midrst.out_data",  64'(out_data),  64'd0);
    cycle("in_rst", 1'b1, 48'h55, 1'b1);
    cycle("in_rst", 1'b1, 48'h66, 1'b1);
    reset_n = 1'b1;
    cycle("post_rst_wr", 1'b1, 48'hA5, 1'b0);
    check("post_rst.head", 64'(out_data), 64'hA5);
    cycle("post_rst_rd", 1'b0, '0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      rnd = {16'($urandom), $urandom};
      cycle("random", 1'($urandom_range(0, 1)), rnd, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
